// File: rtl/riscv_pkg.sv
// Shared core definitions: register-file geometry and ALU control codes.
// The decode stage and the ALU both import this package.
package riscv_pkg;

   localparam int unsigned XLEN       = 64;
   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned NUM_REGS   = 2 ** REG_ADDR_W;

   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

   typedef enum logic [3:0] {
      AluAdd,
      AluSub,
      AluSll,
      AluSlt,
      AluSltu,
      AluXor,
      AluSrl,
      AluSra,
      AluOr,
      AluAnd
   } alu_op_e;

endpackage

// File: rtl/reg_file_wr_dec.sv
// One-hot write-select decoder for the integer register file.
// The select is gated by wr_en, and bit 0 is always low so x0 is never written.
module reg_file_wr_dec
   import riscv_pkg::*;
#(
   parameter int unsigned AddrW   = REG_ADDR_W,
   parameter int unsigned NumRegs = NUM_REGS
) (
   input  logic               wr_en,
   input  logic [AddrW-1:0]   wr_addr,
   output logic [NumRegs-1:0] wr_sel
);

   always_comb begin
      wr_sel = '0;
      if (wr_en) begin
         wr_sel[wr_addr] = 1'b1;
      end
      wr_sel[0] = 1'b0;
   end

endmodule

// File: rtl/reg_file.sv
// 32 x XLEN integer register file: two operand read ports, one write port, one debug port.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto rs1/rs2 (never onto dbg).
module reg_file
   import riscv_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [REG_ADDR_W-1:0] rs1_addr,
   output logic [XLEN-1:0]       rs1_data,
   input  logic [REG_ADDR_W-1:0] rs2_addr,
   output logic [XLEN-1:0]       rs2_data,
   input  logic                  wr_en,
   input  logic [REG_ADDR_W-1:0] rd_addr,
   input  logic [XLEN-1:0]       rd_data,
   input  logic [REG_ADDR_W-1:0] dbg_addr,
   output logic [XLEN-1:0]       dbg_data
);

   logic [NUM_REGS-1:0] wr_sel;
   logic [XLEN-1:0]     regs [NUM_REGS];
   logic [XLEN-1:0]     rs1_arr;
   logic [XLEN-1:0]     rs2_arr;

   reg_file_wr_dec #(
      .AddrW   (REG_ADDR_W),
      .NumRegs (NUM_REGS)
   ) u_wr_dec (
      .wr_en   (wr_en),
      .wr_addr (rd_addr),
      .wr_sel  (wr_sel)
   );

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
      logic [XLEN-1:0] reg_d;
      logic [XLEN-1:0] reg_q;

      always_comb begin
         reg_d = reg_q;
         if (wr_sel[g]) begin
            reg_d = rd_data;
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            reg_q <= '0;
         end else begin
            reg_q <= reg_d;
         end
      end

      assign regs[g] = reg_q;
   end

   // x0 is masked explicitly so the read path never depends on entry 0's flop.
   always_comb begin
      rs1_arr  = (rs1_addr == REG_ZERO) ? '0 : regs[rs1_addr];
      rs2_arr  = (rs2_addr == REG_ZERO) ? '0 : regs[rs2_addr];
      dbg_data = (dbg_addr == REG_ZERO) ? '0 : regs[dbg_addr];
   end

`ifdef REGFILE_BYPASS_EN
   logic rs1_hit;
   logic rs2_hit;

   always_comb begin
      rs1_hit  = wr_en && (rd_addr != REG_ZERO) && (rd_addr == rs1_addr);
      rs2_hit  = wr_en && (rd_addr != REG_ZERO) && (rd_addr == rs2_addr);
      rs1_data = rs1_hit ? rd_data : rs1_arr;
      rs2_data = rs2_hit ? rd_data : rs2_arr;
   end
`else
   always_comb begin
      rs1_data = rs1_arr;
      rs2_data = rs2_arr;
   end
`endif

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: stimulus pushes expected read data into a queue,
// and a monitor pops and compares it against the DUT outputs.
module tb_reg_file;
   import riscv_pkg::*;

`ifdef REGFILE_BYPASS_EN
   localparam bit Byp = 1'b1;
`else
   localparam bit Byp = 1'b0;
`endif

   logic                  clk;
   logic                  rst_n;
   logic [REG_ADDR_W-1:0] rs1_addr;
   logic [XLEN-1:0]       rs1_data;
   logic [REG_ADDR_W-1:0] rs2_addr;
   logic [XLEN-1:0]       rs2_data;
   logic                  wr_en;
   logic [REG_ADDR_W-1:0] rd_addr;
   logic [XLEN-1:0]       rd_data;
   logic [REG_ADDR_W-1:0] dbg_addr;
   logic [XLEN-1:0]       dbg_data;

   typedef struct {
      string           name;
      bit              c1;
      logic [XLEN-1:0] e1;
      bit              c2;
      logic [XLEN-1:0] e2;
      bit              cd;
      logic [XLEN-1:0] ed;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   bit   stim_done = 1'b0;

   reg_file u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rs1_addr (rs1_addr),
      .rs1_data (rs1_data),
      .rs2_addr (rs2_addr),
      .rs2_data (rs2_data),
      .wr_en    (wr_en),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void cmp(string name, string port, logic [XLEN-1:0] act,
                               logic [XLEN-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s.%s: got %h expected %h", name, port, act, exp);
      end
   endfunction

   // Monitor: outputs are combinational, so sample just after each falling clock
   // edge and just after any reset assertion.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk or negedge rst_n);
         #1;
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.c1) cmp(e.name, "rs1", rs1_data, e.e1);
            if (e.c2) cmp(e.name, "rs2", rs2_data, e.e2);
            if (e.cd) cmp(e.name, "dbg", dbg_data, e.ed);
         end
      end
   end

   task automatic push(string name, bit c1, logic [XLEN-1:0] e1, bit c2,
                       logic [XLEN-1:0] e2, bit cd, logic [XLEN-1:0] ed);
      exp_t e;
      e.name = name;
      e.c1 = c1; e.e1 = e1;
      e.c2 = c2; e.e2 = e2;
      e.cd = cd; e.ed = ed;
      exp_q.push_back(e);
   endtask

   task automatic drive(logic we, logic [REG_ADDR_W-1:0] wa, logic [XLEN-1:0] wd,
                        logic [REG_ADDR_W-1:0] a1, logic [REG_ADDR_W-1:0] a2,
                        logic [REG_ADDR_W-1:0] ad);
      wr_en    = we;
      rd_addr  = wa;
      rd_data  = wd;
      rs1_addr = a1;
      rs2_addr = a2;
      dbg_addr = ad;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [XLEN-1:0] v;
      logic [XLEN-1:0] v2;
      logic [REG_ADDR_W-1:0] j;

      rst_n = 1'b0;
      drive(1'b0, 5'd0, '0, 5'd1, 5'd17, 5'd31);
      push("reset_init", 1, '0, 1, '0, 1, '0);
      step();
      rst_n = 1'b1;

      drive(1'b1, 5'd5, 64'hDEAD_BEEF_0123_4567, 5'd5, 5'd5, 5'd5);
      step();
      drive(1'b0, 5'd0, '0, 5'd5, 5'd5, 5'd5);
      push("wr_x5", 1, 64'hDEAD_BEEF_0123_4567, 1, 64'hDEAD_BEEF_0123_4567,
           1, 64'hDEAD_BEEF_0123_4567);
      step();

      drive(1'b1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 5'd0, 5'd0);
      push("x0_wr_cycle", 1, '0, 1, '0, 1, '0);
      step();
      drive(1'b0, 5'd0, '0, 5'd0, 5'd0, 5'd0);
      push("x0_after", 1, '0, 1, '0, 1, '0);
      step();
      push("x0_later", 1, '0, 1, '0, 1, '0);
      step();

      drive(1'b1, 5'd7, 64'd1, 5'd0, 5'd0, 5'd0);
      step();
      drive(1'b1, 5'd7, 64'd2, 5'd7, 5'd7, 5'd7);
      push("raw_same", 1, Byp ? 64'd2 : 64'd1, 1, Byp ? 64'd2 : 64'd1, 1, 64'd1);
      step();
      drive(1'b0, 5'd7, 64'd2, 5'd7, 5'd7, 5'd7);
      push("raw_next", 1, 64'd2, 1, 64'd2, 1, 64'd2);
      step();

      drive(1'b0, 5'd9, 64'h55, 5'd9, 5'd9, 5'd9);
      push("noen_cycle", 1, '0, 1, '0, 1, '0);
      step();
      drive(1'b0, 5'd0, '0, 5'd9, 5'd9, 5'd9);
      push("noen_after", 1, '0, 1, '0, 1, '0);
      step();

      for (int i = 1; i < 32; i++) begin
         v = 64'(i) * 64'h0101_0101_0101_0101;
         drive(1'b1, 5'(i), v, 5'd0, 5'd0, 5'd0);
         step();
      end
      for (int i = 0; i < 32; i++) begin
         j  = 5'(32 - i);
         v  = 64'(i) * 64'h0101_0101_0101_0101;
         v2 = 64'(j) * 64'h0101_0101_0101_0101;
         drive(1'b0, 5'd0, '0, 5'(i), j, 5'(i));
         push($sformatf("sweep_%0d", i), 1, v, 1, v2, 1, v);
         step();
      end

      // Asynchronous reset asserted mid-cycle after the sweep.
      drive(1'b0, 5'd0, '0, 5'd1, 5'd17, 5'd31);
      push("pre_reset", 1, 64'h0101_0101_0101_0101, 1, 64'h1111_1111_1111_1111,
           1, 64'h1F1F_1F1F_1F1F_1F1F);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      push("reset_async", 1, '0, 1, '0, 1, '0);
      #2;

      // A write during reset must be lost.
      drive(1'b1, 5'd3, 64'hAAAA, 5'd3, 5'd1, 5'd31);
      step();
      drive(1'b0, 5'd0, '0, 5'd3, 5'd1, 5'd31);
      #2;
      rst_n = 1'b1;
      push("reset_release", 1, '0, 1, '0, 1, '0);
      step();
      push("reset_hold0", 1, '0, 1, '0, 1, '0);
      step();

      repeat (3) @(posedge clk);
      if (exp_q.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      stim_done = 1'b1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
